vrf_access_ctrl: RTL and testbench

Sequencer and port arbiter for the single-port vector register file RAM (1-cycle read latency) in the vector CVE2 pipeline. It accepts one vector operation at a time and fetches 0–3 source operands serially into operand registers. It then waits for the execute unit's result and writes it back. RAM slots the sequencer does not need go to a vector load/store (LSU) port, and the two requesters alternate when they contend in idle.

---
 rtl/vrf_access_ctrl.sv | 175 +++++++++++++++++
 tb/tb_vrf_access_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_access_ctrl.sv
// Sequencer and RAM-port arbiter for the single-port vector register file.
// Fetches up to three operands serially, waits for the result, writes it back.
module vrf_access_ctrl #(
    parameter int unsigned DataWidth = 128,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 op_req_i,
    output logic                 op_gnt_o,
    input  logic [1:0]           num_operands_i,
    input  logic [AddrWidth-1:0] raddr_a_i,
    input  logic [AddrWidth-1:0] raddr_b_i,
    input  logic [AddrWidth-1:0] raddr_c_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic                 wb_en_i,
    output logic [DataWidth-1:0] rdata_a_o,
    output logic [DataWidth-1:0] rdata_b_o,
    output logic [DataWidth-1:0] rdata_c_o,
    output logic                 operands_valid_o,
    input  logic                 result_valid_i,
    input  logic [DataWidth-1:0] result_i,
    output logic                 done_o,
    output logic                 busy_o,
    input  logic                 lsu_req_i,
    input  logic                 lsu_we_i,
    input  logic [AddrWidth-1:0] lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_gnt_o,
    output logic                 lsu_rvalid_o,
    output logic [DataWidth-1:0] lsu_rdata_o,
    output logic                 ram_req_o,
    output logic                 ram_we_o,
    output logic [AddrWidth-1:0] ram_addr_o,
    output logic [DataWidth-1:0] ram_wdata_o,
    input  logic [DataWidth-1:0] ram_rdata_i
);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, EXEC, WRITE} state_e;

    state_e                 state_q, state_d;
    logic                   prio_lsu_q;
    logic [1:0]             n_q, k_q;
    logic [AddrWidth-1:0]   raddr_a_q, raddr_b_q, raddr_c_q, waddr_q;
    logic                   wb_en_q;
    logic [DataWidth-1:0]   result_q;
    logic                   lsu_rvalid_q;
    logic [AddrWidth-1:0]   read_addr;

    assign read_addr = (k_q == 2'd0) ? raddr_a_q :
                       (k_q == 2'd1) ? raddr_b_q : raddr_c_q;

    always_comb begin
        state_d          = state_q;
        op_gnt_o         = 1'b0;
        lsu_gnt_o        = 1'b0;
        operands_valid_o = 1'b0;
        done_o           = 1'b0;
        ram_req_o        = 1'b0;
        ram_we_o         = 1'b0;
        ram_addr_o       = '0;
        ram_wdata_o      = '0;
        case (state_q)
            IDLE: begin
                op_gnt_o  = op_req_i && !(lsu_req_i && prio_lsu_q) && rst_ni;
                lsu_gnt_o = lsu_req_i && !(op_req_i && !prio_lsu_q) && rst_ni;
                if (op_gnt_o) begin
                    state_d = (num_operands_i != 2'd0) ? READ : EXEC;
                end
            end
            READ: begin
                ram_req_o  = 1'b1;
                ram_addr_o = read_addr;
                if (k_q == n_q - 2'd1) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                lsu_gnt_o = lsu_req_i;
                state_d   = EXEC;
            end
            EXEC: begin
                lsu_gnt_o        = lsu_req_i;
                operands_valid_o = 1'b1;
                if (result_valid_i) begin
                    if (wb_en_q) begin
                        state_d = WRITE;
                    end else begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                ram_req_o   = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = waddr_q;
                ram_wdata_o = result_q;
                done_o      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The sequencer never drives the port in a state where the LSU may be granted.
        if (lsu_gnt_o) begin
            ram_req_o   = 1'b1;
            ram_we_o    = lsu_we_i;
            ram_addr_o  = lsu_addr_i;
            ram_wdata_o = lsu_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            prio_lsu_q   <= 1'b0;
            n_q          <= 2'd0;
            k_q          <= 2'd0;
            raddr_a_q    <= '0;
            raddr_b_q    <= '0;
            raddr_c_q    <= '0;
            waddr_q      <= '0;
            wb_en_q      <= 1'b0;
            result_q     <= '0;
            lsu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lsu_rvalid_q <= lsu_gnt_o && !lsu_we_i;
            if (state_q == IDLE && op_req_i && lsu_req_i) begin
                prio_lsu_q <= !prio_lsu_q;
            end
            if (op_gnt_o) begin
                n_q       <= num_operands_i;
                k_q       <= 2'd0;
                raddr_a_q <= raddr_a_i;
                raddr_b_q <= raddr_b_i;
                raddr_c_q <= raddr_c_i;
                waddr_q   <= waddr_i;
                wb_en_q   <= wb_en_i;
            end else if (state_q == READ) begin
                k_q <= k_q + 2'd1;
            end
            if (state_q == EXEC && result_valid_i) begin
                result_q <= result_i;
            end
        end
    end

    // Operand gi is captured one cycle after its address was issued.
    for (genvar gi = 0; gi < 3; gi++) begin : g_opnd
        logic                 cap_en;
        logic [DataWidth-1:0] opnd_q;

        assign cap_en = (state_q == READ && k_q != 2'd0 && (k_q - 2'd1) == 2'(gi)) ||
                        (state_q == CAPTURE && (n_q - 2'd1) == 2'(gi));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                opnd_q <= '0;
            end else if (op_gnt_o) begin
                opnd_q <= '0;
            end else if (cap_en) begin
                opnd_q <= ram_rdata_i;
            end
        end
    end

    assign rdata_a_o    = g_opnd[0].opnd_q;
    assign rdata_b_o    = g_opnd[1].opnd_q;
    assign rdata_c_o    = g_opnd[2].opnd_q;
    assign busy_o       = (state_q != IDLE);
    assign lsu_rvalid_o = lsu_rvalid_q;
    assign lsu_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_vrf_access_ctrl.sv
// Directed bench for vrf_access_ctrl with a 1-cycle-latency RAM model.
module tb_vrf_access_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         op_req = 1'b0, op_gnt;
    logic [1:0]   num = 2'd0;
    logic [4:0]   ra = '0, rb = '0, rc = '0, wa = '0;
    logic         wb = 1'b0;
    logic [127:0] rd_a, rd_b, rd_c;
    logic         ov, res_v = 1'b0, done, busy;
    logic [127:0] result = '0;
    logic         lsu_req = 1'b0, lsu_we = 1'b0, lsu_gnt, lsu_rvalid;
    logic [4:0]   lsu_addr = '0;
    logic [127:0] lsu_wdata = '0, lsu_rdata;
    logic         ram_req, ram_we;
    logic [4:0]   ram_addr;
    logic [127:0] ram_wdata, ram_rdata = '0;

    logic         pre_we = 1'b0;
    logic [4:0]   pre_addr = '0;
    logic [127:0] pre_data = '0;
    logic [127:0] mem [32];
    int           wr_cnt = 0;
    int           acc_cnt = 0;
    int           total = 0;
    int           bad = 0;
    int           snap;

    always #5 clk = ~clk;

    vrf_access_ctrl #(.DataWidth(128), .AddrWidth(5)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .op_req_i(op_req), .op_gnt_o(op_gnt), .num_operands_i(num),
        .raddr_a_i(ra), .raddr_b_i(rb), .raddr_c_i(rc), .waddr_i(wa), .wb_en_i(wb),
        .rdata_a_o(rd_a), .rdata_b_o(rd_b), .rdata_c_o(rd_c),
        .operands_valid_o(ov), .result_valid_i(res_v), .result_i(result),
        .done_o(done), .busy_o(busy),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
        .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt), .lsu_rvalid_o(lsu_rvalid),
        .lsu_rdata_o(lsu_rdata),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_req) begin
            acc_cnt <= acc_cnt + 1;
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_cnt        <= wr_cnt + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(negedge clk);
    endtask

    task automatic preload(input logic [4:0] a, input logic [127:0] d);
        nxt; pre_we = 1'b1; pre_addr = a; pre_data = d;
        nxt; pre_we = 1'b0;
    endtask

    initial begin
        preload(5'd3, 128'h33);
        preload(5'd7, 128'h77);
        preload(5'd12, 128'hCC);
        preload(5'd9, 128'hABCD);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ram_req", ram_req, 0);
        nxt; rst_n = 1'b1; #1;
        check("rst_op_gnt", op_gnt, 0);
        check("rst_ov", ov, 0);
        check("rst_done", done, 0);
        check("rst_rvalid", lsu_rvalid, 0);
        check("rst_rd_a", rd_a, 0);
        check("rst_acc", acc_cnt, 0);

        // n=3 op with write-back
        nxt; op_req = 1; num = 3; ra = 3; rb = 7; rc = 12; wa = 20; wb = 1; #1;
        check("t1_gnt", op_gnt, 1);
        nxt; op_req = 0; #1;
        check("t1_rd0_req", ram_req, 1);
        check("t1_rd0_we", ram_we, 0);
        check("t1_rd0_addr", ram_addr, 3);
        nxt; #1;
        check("t1_rd1_addr", ram_addr, 7);
        nxt; #1;
        check("t1_rd2_addr", ram_addr, 12);
        check("t1_opa", rd_a, 128'h33);
        nxt; #1;
        check("t1_cap_req", ram_req, 0);
        check("t1_cap_ov", ov, 0);
        check("t1_opb", rd_b, 128'h77);
        nxt; #1;
        check("t1_exec_ov", ov, 1);
        check("t1_opc", rd_c, 128'hCC);
        nxt; res_v = 1; result = 128'hDEAD; #1;
        check("t1_rv_done", done, 0);
        nxt; res_v = 0; #1;
        check("t1_wr_done", done, 1);
        check("t1_wr_we", ram_we, 1);
        check("t1_wr_addr", ram_addr, 20);
        check("t1_wr_data", ram_wdata, 128'hDEAD);
        nxt; #1;
        check("t1_end_done", done, 0);
        check("t1_end_busy", busy, 0);
        check("t1_mem20", mem[20], 128'hDEAD);
        $display("txn n3_op wb addr20 done");

        // n=0 op without write-back
        snap = acc_cnt;
        nxt; op_req = 1; num = 0; wb = 0; #1;
        check("t2_gnt", op_gnt, 1);
        nxt; op_req = 0; res_v = 1; result = 128'h1; #1;
        check("t2_ov", ov, 1);
        check("t2_done", done, 1);
        check("t2_opa_clr", rd_a, 0);
        check("t2_opc_clr", rd_c, 0);
        nxt; res_v = 0; #1;
        check("t2_idle", busy, 0);
        check("t2_no_acc", acc_cnt, snap);
        $display("txn n0_op nowb done");

        // contention in IDLE: op, then LSU, then op
        nxt; op_req = 1; lsu_req = 1; lsu_we = 0; lsu_addr = 9; num = 0; wb = 0; #1;
        check("t3_c1_op", op_gnt, 1);
        check("t3_c1_lsu", lsu_gnt, 0);
        nxt; res_v = 1; #1;
        check("t3_exec_lsu", lsu_gnt, 1);
        check("t3_exec_done", done, 1);
        nxt; res_v = 0; #1;
        check("t3_c2_op", op_gnt, 0);
        check("t3_c2_lsu", lsu_gnt, 1);
        nxt; #1;
        check("t3_c3_op", op_gnt, 1);
        check("t3_c3_lsu", lsu_gnt, 0);
        nxt; op_req = 0; lsu_req = 0; res_v = 1; #1;
        check("t3_done2", done, 1);
        nxt; res_v = 0;
        $display("txn contention alternation");

        // LSU read during EXEC
        nxt; op_req = 1; num = 1; ra = 3; wb = 0; #1;
        check("t4_gnt", op_gnt, 1);
        nxt; op_req = 0; nxt;
        nxt; lsu_req = 1; lsu_we = 0; lsu_addr = 9; #1;
        check("t4_ov", ov, 1);
        check("t4_lsu_gnt", lsu_gnt, 1);
        check("t4_ram_addr", ram_addr, 9);
        nxt; lsu_req = 0; res_v = 1; #1;
        check("t4_rvalid", lsu_rvalid, 1);
        check("t4_rdata", lsu_rdata, 128'hABCD);
        check("t4_opa_keep", rd_a, 128'h33);
        check("t4_done", done, 1);
        nxt; res_v = 0;
        $display("txn lsu read in exec");

        // LSU blocked in READ/WRITE during an n=2 op
        nxt; op_req = 1; num = 2; ra = 7; rb = 12; wa = 21; wb = 1; #1;
        check("t5_gnt", op_gnt, 1);
        nxt; op_req = 0; lsu_req = 1; lsu_addr = 9; #1;
        check("t5_rd0_lsu", lsu_gnt, 0);
        check("t5_rd0_addr", ram_addr, 7);
        nxt; #1;
        check("t5_rd1_lsu", lsu_gnt, 0);
        check("t5_rd1_addr", ram_addr, 12);
        nxt; #1;
        check("t5_cap_lsu", lsu_gnt, 1);
        check("t5_cap_addr", ram_addr, 9);
        nxt; res_v = 1; result = 128'h5555; #1;
        check("t5_exec_lsu", lsu_gnt, 1);
        check("t5_opa", rd_a, 128'h77);
        check("t5_opb", rd_b, 128'hCC);
        nxt; res_v = 0; #1;
        check("t5_wr_lsu", lsu_gnt, 0);
        check("t5_wr_addr", ram_addr, 21);
        check("t5_wr_done", done, 1);
        check("t5_wr_rvalid", lsu_rvalid, 1);
        nxt; #1;
        check("t5_idle_lsu", lsu_gnt, 1);
        check("t5_idle_rvalid", lsu_rvalid, 0);
        nxt; lsu_req = 0;
        $display("txn lsu blocked in read/write");

        // reset during READ
        snap = wr_cnt;
        nxt; op_req = 1; num = 3; ra = 3; rb = 7; rc = 12; wa = 22; wb = 1; #1;
        check("t6_gnt", op_gnt, 1);
        nxt; op_req = 0; #1;
        check("t6_rd_req", ram_req, 1);
        rst_n = 1'b0; #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_req", ram_req, 0);
        check("t6_rst_ov", ov, 0);
        check("t6_rst_done", done, 0);
        nxt; nxt; rst_n = 1'b1;
        nxt; #1;
        check("t6_no_write", wr_cnt, snap);
        check("t6_opa_rst", rd_a, 0);
        nxt; op_req = 1; num = 1; ra = 12; wb = 0; #1;
        check("t6_regnt", op_gnt, 1);
        nxt; op_req = 0; #1;
        check("t6_re_addr", ram_addr, 12);
        nxt; nxt; res_v = 1; #1;
        check("t6_re_opa", rd_a, 128'hCC);
        check("t6_re_done", done, 1);
        nxt; res_v = 0;
        $display("txn reset mid-op recovery");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
